// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared types and defaults for the FX2 write scheduler
package fx2_pkg;
  localparam int         DEF_WORD_W  = 16;
  localparam logic [1:0] DEF_EP0_ADR = 2'b00;
  localparam logic [1:0] DEF_EP1_ADR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    PK_SETUP,
    PK_STROBE
  } state_t;
endpackage

// File: rtl/fx2_idle_timer.sv
// rtl/fx2_idle_timer.sv - per-endpoint dirty flag and saturating idle counter
module fx2_idle_timer #(
  parameter int IDLE_TO = 4096,
  parameter int TO_W    = 13
) (
  input  logic FX2_IFCLK,
  input  logic RESET,
  input  logic strobe,
  input  logic commit,
  output logic pending
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(IDLE_TO);

  logic            dirty;
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge FX2_IFCLK) begin
    if (RESET) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else if (strobe) begin
      dirty    <= 1'b1;
      idle_cnt <= '0;
    end else if (commit) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else if (dirty && idle_cnt != LIMIT) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  // An endpoint never written since its last commit stays clean and silent.
  assign pending = dirty && (idle_cnt == LIMIT);
endmodule

// File: rtl/fx2_wr_sched.sv
// rtl/fx2_wr_sched.sv - round-robin FX2 slave-FIFO write scheduler for two word sources
module fx2_wr_sched
  import fx2_pkg::*;
#(
  parameter int         WORD_W  = DEF_WORD_W,
  parameter logic [1:0] EP0_ADR = DEF_EP0_ADR,
  parameter logic [1:0] EP1_ADR = DEF_EP1_ADR,
  parameter int         IDLE_TO = 4096,
  parameter int         TO_W    = 13
) (
  input  logic              FX2_IFCLK,
  input  logic              RESET,
  input  logic [1:0]        REQ,
  input  logic [WORD_W-1:0] DATA0,
  input  logic [WORD_W-1:0] DATA1,
  output logic [1:0]        ACK,
  input  logic              FX2_FLAGA,
  input  logic              FX2_FLAGB,
  output logic              FX2_SLWR,
  output logic              FX2_PKTEND,
  output logic [1:0]        FX2_FIFOADR,
  output logic [WORD_W-1:0] FX2_FD,
  output logic              FX2_SLOE,
  output logic              FX2_SLRD
);
  state_t            state, state_n;
  logic [1:0]        req_meta, req_s;
  logic              g, g_n;
  logic              last_grant, lg_n;
  logic              pick;
  logic              slwr_n, pktend_n;
  logic [1:0]        adr_n, ack_n;
  logic [WORD_W-1:0] fd_n;
  logic [1:0]        flags, elig, pend;

  assign FX2_SLOE = 1'b1;
  assign FX2_SLRD = 1'b1;
  assign flags    = {FX2_FLAGB, FX2_FLAGA};
  assign elig     = req_s & ~ACK & flags;

  fx2_idle_timer #(.IDLE_TO(IDLE_TO), .TO_W(TO_W)) u_tmr0 (
    .FX2_IFCLK (FX2_IFCLK),
    .RESET     (RESET),
    .strobe    (state == STROBE && !g),
    .commit    (state == PK_STROBE && !g),
    .pending   (pend[0])
  );

  fx2_idle_timer #(.IDLE_TO(IDLE_TO), .TO_W(TO_W)) u_tmr1 (
    .FX2_IFCLK (FX2_IFCLK),
    .RESET     (RESET),
    .strobe    (state == STROBE && g),
    .commit    (state == PK_STROBE && g),
    .pending   (pend[1])
  );

  always_comb begin
    state_n  = state;
    g_n      = g;
    lg_n     = last_grant;
    pick     = 1'b0;
    slwr_n   = 1'b1;
    pktend_n = 1'b1;
    adr_n    = FX2_FIFOADR;
    fd_n     = FX2_FD;
    ack_n    = ACK;
    case (state)
      IDLE: begin
        // Writes outrank commits; on a tie the channel not served last wins.
        if (|elig) begin
          pick    = (elig == 2'b11) ? ~last_grant : elig[1];
          g_n     = pick;
          lg_n    = pick;
          fd_n    = pick ? DATA1 : DATA0;
          adr_n   = pick ? EP1_ADR : EP0_ADR;
          state_n = SETUP;
        end else if (|pend) begin
          g_n     = ~pend[0];
          adr_n   = pend[0] ? EP0_ADR : EP1_ADR;
          state_n = PK_SETUP;
        end
      end
      SETUP: begin
        if (flags[g]) begin
          slwr_n  = 1'b0;
          state_n = STROBE;
        end
      end
      STROBE: begin
        ack_n[g] = 1'b1;
        state_n  = HOLD;
      end
      HOLD: begin
        if (!req_s[g]) begin
          ack_n[g] = 1'b0;
          state_n  = IDLE;
        end
      end
      PK_SETUP: begin
        pktend_n = 1'b0;
        state_n  = PK_STROBE;
      end
      PK_STROBE: state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge FX2_IFCLK) begin
    if (RESET) begin
      req_meta    <= 2'b00;
      req_s       <= 2'b00;
      state       <= IDLE;
      g           <= 1'b0;
      last_grant  <= 1'b1;
      ACK         <= 2'b00;
      FX2_SLWR    <= 1'b1;
      FX2_PKTEND  <= 1'b1;
      FX2_FIFOADR <= EP0_ADR;
      FX2_FD      <= '0;
    end else begin
      req_meta    <= REQ;
      req_s       <= req_meta;
      state       <= state_n;
      g           <= g_n;
      last_grant  <= lg_n;
      ACK         <= ack_n;
      FX2_SLWR    <= slwr_n;
      FX2_PKTEND  <= pktend_n;
      FX2_FIFOADR <= adr_n;
      FX2_FD      <= fd_n;
    end
  end
endmodule
